// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands, decoded fields, extended immediate and control.
// Snoops the write-back port so captured operands match the register file at load and while held.
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Stall,
  input  logic                         Flush,
  input  logic [31:0]                  InstrIn,
  input  logic [DATA_WIDTH-1:0]        PCPlus4In,
  input  logic signed [DATA_WIDTH-1:0] ReadData1In,
  input  logic signed [DATA_WIDTH-1:0] ReadData2In,
  input  logic                         RegWriteIn,
  input  logic                         MemReadIn,
  input  logic                         MemWriteIn,
  input  logic                         MemToRegIn,
  input  logic                         ALUSrcIn,
  input  logic                         RegDstIn,
  input  logic                         ZeroExtIn,
  input  logic [3:0]                   ALUOpIn,
  input  logic                         WBRegWrite,
  input  logic [4:0]                   WBAddr,
  input  logic signed [DATA_WIDTH-1:0] WBData,
  output logic                         ValidOut,
  output logic [DATA_WIDTH-1:0]        PCPlus4Out,
  output logic signed [DATA_WIDTH-1:0] RsData,
  output logic signed [DATA_WIDTH-1:0] RtData,
  output logic signed [DATA_WIDTH-1:0] ImmOut,
  output logic [4:0]                   RsOut,
  output logic [4:0]                   RtOut,
  output logic [4:0]                   RdOut,
  output logic [4:0]                   ShamtOut,
  output logic                         RegWriteOut,
  output logic                         MemReadOut,
  output logic                         MemWriteOut,
  output logic                         MemToRegOut,
  output logic                         ALUSrcOut,
  output logic                         RegDstOut,
  output logic [3:0]                   ALUOpOut
);

  // Addresses 0, 26 and 27 are never written by the register file, so they must never be snooped.
  function automatic logic wb_hit(input logic en, input logic [4:0] wb_addr,
                                  input logic [4:0] addr);
    return en && (wb_addr == addr) && (addr != 5'd0) && (addr != 5'd26) && (addr != 5'd27);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] ext_imm(input logic [15:0] imm,
                                                           input logic zero_ext);
    logic signed [DATA_WIDTH-1:0] r;
    if (zero_ext) r = {{(DATA_WIDTH-16){1'b0}}, imm};
    else          r = {{(DATA_WIDTH-16){imm[15]}}, imm};
    return r;
  endfunction

  logic                         vld_p1;
  logic [DATA_WIDTH-1:0]        pc_p1;
  logic signed [DATA_WIDTH-1:0] rs_data_p1;
  logic signed [DATA_WIDTH-1:0] rt_data_p1;
  logic signed [DATA_WIDTH-1:0] imm_p1;
  logic [4:0]                   rs_p1;
  logic [4:0]                   rt_p1;
  logic [4:0]                   rd_p1;
  logic [4:0]                   shamt_p1;
  logic                         reg_write_p1;
  logic                         mem_read_p1;
  logic                         mem_write_p1;
  logic                         mem_to_reg_p1;
  logic                         alu_src_p1;
  logic                         reg_dst_p1;
  logic [3:0]                   alu_op_p1;

  logic [4:0]                   rs_p0;
  logic [4:0]                   rt_p0;
  logic signed [DATA_WIDTH-1:0] rs_load_p0;
  logic signed [DATA_WIDTH-1:0] rt_load_p0;
  logic signed [DATA_WIDTH-1:0] rs_hold_p0;
  logic signed [DATA_WIDTH-1:0] rt_hold_p0;
  logic                         unused_opcode;

  assign rs_p0         = InstrIn[25:21];
  assign rt_p0         = InstrIn[20:16];
  assign unused_opcode = ^InstrIn[31:26];

  // The register file reads on negedge, before the current write-back commits, so its
  // data is stale on a same-cycle hit; held operands must also follow later writes.
  always_comb begin
    rs_load_p0 = ReadData1In;
    rt_load_p0 = ReadData2In;
    rs_hold_p0 = rs_data_p1;
    rt_hold_p0 = rt_data_p1;
    if (BYPASS_EN) begin
      if (wb_hit(WBRegWrite, WBAddr, rs_p0)) rs_load_p0 = WBData;
      if (wb_hit(WBRegWrite, WBAddr, rt_p0)) rt_load_p0 = WBData;
      if (wb_hit(WBRegWrite, WBAddr, rs_p1)) rs_hold_p0 = WBData;
      if (wb_hit(WBRegWrite, WBAddr, rt_p1)) rt_hold_p0 = WBData;
    end
  end

  // ---- ID -> EX stage boundary ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1        <= 1'b0;
      pc_p1         <= '0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      shamt_p1      <= '0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_src_p1    <= 1'b0;
      reg_dst_p1    <= 1'b0;
      alu_op_p1     <= '0;
    end else if (Flush) begin
      vld_p1        <= 1'b0;
      pc_p1         <= '0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      shamt_p1      <= '0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_src_p1    <= 1'b0;
      reg_dst_p1    <= 1'b0;
      alu_op_p1     <= '0;
    end else if (Stall) begin
      rs_data_p1    <= rs_hold_p0;
      rt_data_p1    <= rt_hold_p0;
    end else begin
      vld_p1        <= 1'b1;
      pc_p1         <= PCPlus4In;
      rs_data_p1    <= rs_load_p0;
      rt_data_p1    <= rt_load_p0;
      imm_p1        <= ext_imm(InstrIn[15:0], ZeroExtIn);
      rs_p1         <= rs_p0;
      rt_p1         <= rt_p0;
      rd_p1         <= InstrIn[15:11];
      shamt_p1      <= InstrIn[10:6];
      reg_write_p1  <= RegWriteIn;
      mem_read_p1   <= MemReadIn;
      mem_write_p1  <= MemWriteIn;
      mem_to_reg_p1 <= MemToRegIn;
      alu_src_p1    <= ALUSrcIn;
      reg_dst_p1    <= RegDstIn;
      alu_op_p1     <= ALUOpIn;
    end
  end

  assign ValidOut    = vld_p1;
  assign PCPlus4Out  = pc_p1;
  assign RsData      = rs_data_p1;
  assign RtData      = rt_data_p1;
  assign ImmOut      = imm_p1;
  assign RsOut       = rs_p1;
  assign RtOut       = rt_p1;
  assign RdOut       = rd_p1;
  assign ShamtOut    = shamt_p1;
  assign RegWriteOut = reg_write_p1;
  assign MemReadOut  = mem_read_p1;
  assign MemWriteOut = mem_write_p1;
  assign MemToRegOut = mem_to_reg_p1;
  assign ALUSrcOut   = alu_src_p1;
  assign RegDstOut   = reg_dst_p1;
  assign ALUOpOut    = alu_op_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a cycle-level expectation model checked every negedge,
// plus hand-computed literal checks one time unit after the active edge.
module tb_id_ex_stage;

  logic               Clk, Reset, Stall, Flush;
  logic [31:0]        InstrIn, PCPlus4In;
  logic signed [31:0] ReadData1In, ReadData2In, WBData;
  logic               RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn, ALUSrcIn, RegDstIn, ZeroExtIn;
  logic [3:0]         ALUOpIn;
  logic               WBRegWrite;
  logic [4:0]         WBAddr;
  logic               ValidOut;
  logic [31:0]        PCPlus4Out;
  logic signed [31:0] RsData, RtData, ImmOut;
  logic [4:0]         RsOut, RtOut, RdOut, ShamtOut;
  logic               RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, ALUSrcOut, RegDstOut;
  logic [3:0]         ALUOpOut;

  int tests = 0;
  int fails = 0;

  id_ex_stage #(.DATA_WIDTH(32), .BYPASS_EN(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InstrIn(InstrIn),
    .PCPlus4In(PCPlus4In), .ReadData1In(ReadData1In), .ReadData2In(ReadData2In),
    .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .MemToRegIn(MemToRegIn), .ALUSrcIn(ALUSrcIn), .RegDstIn(RegDstIn), .ZeroExtIn(ZeroExtIn),
    .ALUOpIn(ALUOpIn), .WBRegWrite(WBRegWrite), .WBAddr(WBAddr), .WBData(WBData),
    .ValidOut(ValidOut), .PCPlus4Out(PCPlus4Out), .RsData(RsData), .RtData(RtData),
    .ImmOut(ImmOut), .RsOut(RsOut), .RtOut(RtOut), .RdOut(RdOut), .ShamtOut(ShamtOut),
    .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .MemToRegOut(MemToRegOut), .ALUSrcOut(ALUSrcOut), .RegDstOut(RegDstOut), .ALUOpOut(ALUOpOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic        rw, mr, mw, m2r, asrc, rdst;
    logic [3:0]  aluop;
  } view_t;

  view_t exp_v, act_v;
  assign act_v = {ValidOut, PCPlus4Out, RsData, RtData, ImmOut, RsOut, RtOut, RdOut, ShamtOut,
                  RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, ALUSrcOut, RegDstOut, ALUOpOut};

  // A write-back is visible to the stage only for registers the register file really writes.
  function automatic logic writes_reg(input logic [4:0] r);
    return WBRegWrite && (WBAddr == r) && !(r inside {5'd0, 5'd26, 5'd27});
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf_val);
    return writes_reg(r) ? WBData : rf_val;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset || Flush) exp_v <= '0;
    else if (Stall) begin
      exp_v.rsd <= operand(exp_v.rs, exp_v.rsd);
      exp_v.rtd <= operand(exp_v.rt, exp_v.rtd);
    end else begin
      exp_v <= '{valid: 1'b1, pc: PCPlus4In,
                 rsd: operand(InstrIn[25:21], ReadData1In),
                 rtd: operand(InstrIn[20:16], ReadData2In),
                 imm: ZeroExtIn ? {16'h0000, InstrIn[15:0]} : {{16{InstrIn[15]}}, InstrIn[15:0]},
                 rs: InstrIn[25:21], rt: InstrIn[20:16], rd: InstrIn[15:11], sh: InstrIn[10:6],
                 rw: RegWriteIn, mr: MemReadIn, mw: MemWriteIn, m2r: MemToRegIn,
                 asrc: ALUSrcIn, rdst: RegDstIn, aluop: ALUOpIn};
    end
  end

  always @(negedge Clk) begin
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL model_cmp t=%0t: got %h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic rw, input logic mw, input logic asrc, input logic zext,
                       input logic [3:0] op);
    InstrIn = instr; ReadData1In = rd1; ReadData2In = rd2;
    RegWriteIn = rw; MemWriteIn = mw; ALUSrcIn = asrc; ZeroExtIn = zext; ALUOpIn = op;
    MemReadIn = 1'b0; MemToRegIn = 1'b0; RegDstIn = rw & ~asrc;
    PCPlus4In = PCPlus4In + 32'd4;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    WBRegWrite = en; WBAddr = addr; WBData = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; PCPlus4In = 32'h0000_0100;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) cycle();
    chk("reset_valid", {31'b0, ValidOut}, 32'd0);
    chk("reset_rsdata", RsData, 32'd0);
    Reset = 1'b0;

    // add $10,$8,$9
    drive(32'h01095020, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("add_rsdata", RsData, 32'd108);
    chk("add_rtdata", RtData, 32'd109);
    chk("add_rs", {27'b0, RsOut}, 32'd8);
    chk("add_rt", {27'b0, RtOut}, 32'd9);
    chk("add_rd", {27'b0, RdOut}, 32'd10);
    chk("add_regwrite", {31'b0, RegWriteOut}, 32'd1);
    chk("add_valid", {31'b0, ValidOut}, 32'd1);

    // Same-cycle write-back bypass on load
    wb(1'b1, 5'd8, 32'd500);
    drive(32'h01095020, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("bypass_rs", RsData, 32'd500);
    chk("bypass_rt_untouched", RtData, 32'd109);
    wb(1'b1, 5'd26, 32'd500);
    drive(32'h01095020, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("wb26_other_reg", RsData, 32'd108);
    // rs=$26 rt=$27 rd=$1: protected addresses never bypass
    drive(32'h035B0800, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("protected26_rs", RsData, 32'd108);
    wb(1'b1, 5'd27, 32'd500);
    drive(32'h035B0800, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("protected27_rt", RtData, 32'd109);
    // Held protected register ignores write-back
    Stall = 1'b1; wb(1'b1, 5'd26, 32'd1234);
    cycle();
    chk("hold_protected26", RsData, 32'd108);
    Stall = 1'b0;
    // rs=$0 rt=$9 rd=$1: $0 never bypasses, $9 does
    wb(1'b1, 5'd0, 32'd500);
    drive(32'h00090800, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("protected0_rs", RsData, 32'd108);
    wb(1'b1, 5'd9, 32'd600);
    drive(32'h00090800, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("bypass_rt", RtData, 32'd600);

    // Stall three cycles with write-back to $8 on the second
    wb(1'b0, 5'd0, 32'd0);
    drive(32'h01095020, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    Stall = 1'b1;
    drive(32'hFFFF_FFFF, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    cycle();
    chk("stall1_rsdata", RsData, 32'd108);
    wb(1'b1, 5'd8, 32'd777);
    cycle();
    chk("stall2_rsdata", RsData, 32'd777);
    wb(1'b0, 5'd0, 32'd0);
    cycle();
    chk("stall3_rsdata", RsData, 32'd777);
    chk("stall3_rtdata", RtData, 32'd109);
    chk("stall3_rd", {27'b0, RdOut}, 32'd10);
    chk("stall3_valid", {31'b0, ValidOut}, 32'd1);
    chk("stall3_aluop", {28'b0, ALUOpOut}, 32'd2);
    wb(1'b1, 5'd12, 32'd999);
    cycle();
    chk("stall_unrelated_wb", RsData, 32'd777);
    Stall = 1'b0; wb(1'b0, 5'd0, 32'd0);

    // rs=rt=$5: both operands follow a held write-back
    drive(32'h00A51820, 32'd50, 32'd50, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    Stall = 1'b1; wb(1'b1, 5'd5, 32'd55);
    cycle();
    chk("same_reg_rs", RsData, 32'd55);
    chk("same_reg_rt", RtData, 32'd55);
    Stall = 1'b0; wb(1'b0, 5'd0, 32'd0);

    // Immediate 0xFFFC, sign then zero extension
    drive(32'h2022FFFC, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
    cycle();
    chk("imm_sext", ImmOut, 32'hFFFF_FFFC);
    drive(32'h2022FFFC, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1);
    cycle();
    chk("imm_zext", ImmOut, 32'h0000_FFFC);

    // sw $8,4($29) held, then Flush+Stall together
    drive(32'hAFA80004, 32'd300, 32'd8, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    cycle();
    chk("store_memwrite", {31'b0, MemWriteOut}, 32'd1);
    Stall = 1'b1;
    cycle();
    Flush = 1'b1;
    cycle();
    chk("flush_memwrite", {31'b0, MemWriteOut}, 32'd0);
    chk("flush_regwrite", {31'b0, RegWriteOut}, 32'd0);
    chk("flush_valid", {31'b0, ValidOut}, 32'd0);
    Flush = 1'b0; Stall = 1'b0;

    // Asynchronous reset mid-cycle while stalled and valid
    drive(32'h01095020, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("pre_reset_rsdata", RsData, 32'd108);
    Stall = 1'b1;
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'b0, ValidOut}, 32'd0);
    chk("async_reset_rsdata", RsData, 32'd0);
    chk("async_reset_rd", {27'b0, RdOut}, 32'd0);
    cycle();
    Reset = 1'b0; Stall = 1'b0;
    drive(32'h01095020, 32'd108, 32'd109, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2);
    cycle();
    chk("post_reset_valid", {31'b0, ValidOut}, 32'd1);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
